// File: rtl/mips_tb_result_monitor.sv
// rtl/mips_tb_result_monitor.sv - run monitor: boot check, halt detect, settle, masked $v0 compare, sticky verdict
//
// Ports:
//   clk            system clock, all logic on posedge
//   reset          synchronous, active-high; overrides clk_enable
//   clk_enable     CPU clock enable; monitor only advances when high
//   active         CPU active flag
//   instr_address  CPU fetch address
//   register_v0    CPU $v0 observation
//   expected_v0    expected final $v0
//   cmp_mask       compare mask, 1 = bit checked
//   done           verdict valid (sticky)
//   pass / fail    verdict (sticky, mutually exclusive)
//   fail_code      0 none, 1 boot vector, 2 wrong result, 3 timeout, 4 active stuck
//   cycle_count    enabled cycles from boot to verdict, saturating
//   v0_captured    register_v0 sampled at compare
module mips_tb_result_monitor #(
    parameter int                    DATA_WIDTH     = 32,
    parameter logic [DATA_WIDTH-1:0] RESET_VECTOR   = 32'hBFC00000,
    parameter logic [DATA_WIDTH-1:0] HALT_ADDR      = 32'h00000000,
    parameter int                    TIMEOUT_CYCLES = 1000,
    parameter int                    SETTLE_CYCLES  = 4,
    parameter int                    CNT_WIDTH      = 16
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  clk_enable,
    input  logic                  active,
    input  logic [DATA_WIDTH-1:0] instr_address,
    input  logic [DATA_WIDTH-1:0] register_v0,
    input  logic [DATA_WIDTH-1:0] expected_v0,
    input  logic [DATA_WIDTH-1:0] cmp_mask,
    output logic                  done,
    output logic                  pass,
    output logic                  fail,
    output logic [2:0]            fail_code,
    output logic [CNT_WIDTH-1:0]  cycle_count,
    output logic [DATA_WIDTH-1:0] v0_captured
);

    localparam int SW = (SETTLE_CYCLES > 1) ? $clog2(SETTLE_CYCLES) : 1;
    localparam logic [CNT_WIDTH-1:0] TIMEOUT_LAST = CNT_WIDTH'(TIMEOUT_CYCLES - 1);
    localparam logic [SW-1:0]        SETTLE_LAST  = SW'(SETTLE_CYCLES - 1);

    typedef enum logic [2:0] {
        ST_BOOT,
        ST_RUN,
        ST_SETTLE,
        ST_PASS,
        ST_FAIL
    } state_t;

    state_t                  r_state;
    logic                    r_done;
    logic                    r_pass;
    logic                    r_fail;
    logic [2:0]              r_fail_code;
    logic [CNT_WIDTH-1:0]    r_cycle_count;
    logic [DATA_WIDTH-1:0]   r_v0_captured;
    logic [SW-1:0]           r_settle_cnt;

    state_t                  w_state_nxt;
    logic [2:0]              w_code_nxt;
    logic [CNT_WIDTH-1:0]    w_count_nxt;
    logic [CNT_WIDTH-1:0]    w_count_inc;
    logic [DATA_WIDTH-1:0]   w_v0_nxt;
    logic [SW-1:0]           w_settle_nxt;
    logic                    w_match;

    assign w_count_inc = (r_cycle_count == {CNT_WIDTH{1'b1}}) ? r_cycle_count
                                                               : r_cycle_count + CNT_WIDTH'(1);
    assign w_match     = ((register_v0 & cmp_mask) == (expected_v0 & cmp_mask));

    always_comb begin
        w_state_nxt  = r_state;
        w_code_nxt   = r_fail_code;
        w_count_nxt  = r_cycle_count;
        w_v0_nxt     = r_v0_captured;
        w_settle_nxt = r_settle_cnt;
        if (clk_enable) begin
            case (r_state)
                ST_BOOT: begin
                    if (instr_address == RESET_VECTOR) begin
                        w_state_nxt = ST_RUN;
                        w_count_nxt = CNT_WIDTH'(1);
                    end else begin
                        w_state_nxt = ST_FAIL;
                        w_code_nxt  = 3'd1;
                    end
                end
                ST_RUN: begin
                    w_count_nxt = w_count_inc;
                    // Halt is checked first so a halt on the last allowed cycle still settles.
                    if (instr_address == HALT_ADDR) begin
                        w_state_nxt  = ST_SETTLE;
                        w_settle_nxt = '0;
                    end else if (r_cycle_count == TIMEOUT_LAST) begin
                        w_state_nxt = ST_FAIL;
                        w_code_nxt  = 3'd3;
                    end
                end
                ST_SETTLE: begin
                    w_count_nxt = w_count_inc;
                    if (!active) begin
                        w_v0_nxt = register_v0;
                        if (w_match) begin
                            w_state_nxt = ST_PASS;
                        end else begin
                            w_state_nxt = ST_FAIL;
                            w_code_nxt  = 3'd2;
                        end
                    end else if (r_settle_cnt == SETTLE_LAST) begin
                        w_state_nxt = ST_FAIL;
                        w_code_nxt  = 3'd4;
                    end else begin
                        w_settle_nxt = r_settle_cnt + SW'(1);
                    end
                end
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state       <= ST_BOOT;
            r_done        <= 1'b0;
            r_pass        <= 1'b0;
            r_fail        <= 1'b0;
            r_fail_code   <= 3'd0;
            r_cycle_count <= '0;
            r_v0_captured <= '0;
            r_settle_cnt  <= '0;
        end else begin
            r_state       <= w_state_nxt;
            // Verdict flags are their own flops so they never glitch on a state-decode transition.
            r_done        <= (w_state_nxt == ST_PASS) || (w_state_nxt == ST_FAIL);
            r_pass        <= (w_state_nxt == ST_PASS);
            r_fail        <= (w_state_nxt == ST_FAIL);
            r_fail_code   <= w_code_nxt;
            r_cycle_count <= w_count_nxt;
            r_v0_captured <= w_v0_nxt;
            r_settle_cnt  <= w_settle_nxt;
        end
    end

    assign done        = r_done;
    assign pass        = r_pass;
    assign fail        = r_fail;
    assign fail_code   = r_fail_code;
    assign cycle_count = r_cycle_count;
    assign v0_captured = r_v0_captured;

endmodule

// File: doc/mips_tb_result_monitor.md
Name: mips_tb_result_monitor

Overview:
- Parametrised, synthesizable run monitor for the Harvard CPU directed-test benches.
- Replaces per-test ad-hoc assertion blocks.
- Watches the CPU fetch address and `active`, checks the boot vector, and detects halt (jump to HALT_ADDR).
- Waits for `active` to drop, compares masked `register_v0` against an expected value, enforces a cycle timeout, and latches a sticky verdict plus fail code and cycle count.

Parameters:
- DATA_WIDTH, 32, width of register_v0 / expected_v0 / address buses
- RESET_VECTOR, 32'hBFC00000, required instr_address on first enabled cycle after reset
- HALT_ADDR, 32'h00000000, fetch address that marks program end
- TIMEOUT_CYCLES, 1000, max enabled cycles in RUN before timeout (>=2)
- SETTLE_CYCLES, 4, max enabled cycles after halt fetch for active to fall (>=1)
- CNT_WIDTH, 16, width of cycle_count

Ports:
- clk  input  1  system clock, all logic on posedge
- reset  input  1  synchronous, active-high
- clk_enable  input  1  same enable as CPU; monitor state advances only when high
- active  input  1  CPU active flag
- instr_address  input  DATA_WIDTH  CPU fetch address
- register_v0  input  DATA_WIDTH  CPU $v0 observation port
- expected_v0  input  DATA_WIDTH  expected final $v0, static during a run
- cmp_mask  input  DATA_WIDTH  bitwise compare mask (1 = bit checked)
- done  output  1  verdict valid, sticky
- pass  output  1  run passed, sticky
- fail  output  1  run failed, sticky
- fail_code  output  3  0 none, 1 bad boot vector, 2 wrong result, 3 timeout, 4 active stuck
- cycle_count  output  CNT_WIDTH  enabled cycles from boot to verdict, saturating
- v0_captured  output  DATA_WIDTH  register_v0 value at compare

Behaviour:
- Reset: synchronous, active-high, takes priority over clk_enable.
  - State to BOOT; done=pass=fail=0; fail_code=0; cycle_count=0; v0_captured=0.
  - Reset asserted mid-run (any state, including verdict states) aborts and returns to BOOT.
- clk_enable=0: all registers hold. Timeout and settle counters do not advance.
- States, evaluated on posedge with clk_enable=1 and reset=0:
  - BOOT:
    - instr_address==RESET_VECTOR -> RUN, cycle_count=1.
    - Otherwise -> FAIL, code 1.
  - RUN: cycle_count increments, saturating at all-ones.
    - instr_address==HALT_ADDR -> SETTLE; settle counter=0.
    - Else if cycle_count==TIMEOUT_CYCLES-1 -> FAIL, code 3.
    - Halt and timeout in the same cycle: halt wins.
  - SETTLE: cycle_count increments.
    - active==0 -> capture register_v0 into v0_captured and compare.
      - Equal if (register_v0 & cmp_mask)==(expected_v0 & cmp_mask).
      - Equal -> PASS; else -> FAIL, code 2.
    - active==1 and settle counter==SETTLE_CYCLES-1 -> FAIL, code 4.
    - Otherwise settle counter++.
    - instr_address is ignored in SETTLE.
  - PASS / FAIL: terminal until reset.
    - done=1; exactly one of pass/fail=1.
    - fail_code, cycle_count and v0_captured frozen.
- Outputs are registered, asserted the cycle after the deciding edge, never glitch.
- pass and fail are never both 1.
- fail_code is nonzero iff fail=1.

Test Plan:
- Boot at 0xBFC00000, fetch 0xBFC00004..0xBFC0000C, then instr_address=0, active falls next cycle, v0=5, expected=5, mask=all-ones -> pass=1, fail_code=0, v0_captured=5, cycle_count=6.
- Same sequence, v0=6, expected=5 -> fail=1, fail_code=2, v0_captured=6.
- v0=0x12345605, expected=5, mask=0x000000FF -> pass=1. Mask=all-ones -> fail, code 2.
- First fetch after reset at 0x00000004 -> fail=1, code 1, cycle_count=0.
- TIMEOUT_CYCLES=10, PC loops at 0xBFC00008 -> fail, code 3, cycle_count=10.
  - Halt fetch landing exactly on cycle 9 -> SETTLE, no timeout.
- Halt reached, active held high 4 cycles (SETTLE_CYCLES=4) -> fail, code 4.
  - clk_enable low 3 cycles mid-SETTLE -> verdict delayed by 3 cycles.
  - Reset pulse after verdict -> all outputs 0, state BOOT.
